axin_drr_sched: RTL and testbench

- Deficit-round-robin (DRR) grant scheduler for NIN AXIN packet sources that share one outgoing packet stream.
- Produces a one-hot, packet-locked grant vector that steers a downstream mux/merge stage.
- Keeps a signed byte-deficit counter per port, so link bandwidth is shared in proportion to per-port quanta instead of per packet.
- Consumes the accepted-beat strobes of the granted source to account bytes and to detect packet end or abort.

---
 rtl/axin_drr_sched.sv | 141 ++++++++++++++
 tb/tb_axin_drr_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axin_drr_sched.sv
// Deficit-round-robin grant scheduler for NIN AXIN packet sources.
// Packet-locked one-hot grant with a signed, saturating byte deficit per port.
module axin_drr_sched #(
    parameter int NIN   = 4,
    parameter int DW    = 64,
    parameter int WBITS = $clog2(DW/8),
    parameter int QW    = 12,
    parameter int CW    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [NIN-1:0]          i_req,
    input  logic [NIN*QW-1:0]       i_quantum,
    input  logic                    i_beat,
    input  logic [WBITS-1:0]        i_bytes,
    input  logic                    i_last,
    input  logic                    i_abort,
    output logic [NIN-1:0]          o_grant,
    output logic                    o_busy,
    output logic [$clog2(NIN)-1:0]  o_ptr
);

    localparam int PW = $clog2(NIN);
    localparam logic [CW-1:0] DEF_MIN = {1'b1, {(CW-1){1'b0}}};
    localparam logic [WBITS:0] FULL_BEAT = (WBITS+1)'(DW/8);

    generate
        if (CW < QW + 2) begin : g_cw_chk
            $error("axin_drr_sched: CW must be at least QW+2");
        end
        if (NIN < 2) begin : g_nin_chk
            $error("axin_drr_sched: NIN must be at least 2");
        end
    endgenerate

    typedef enum logic {
        SCAN = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_ptr_inc;
    logic            r_fresh;
    logic            w_fresh_nxt;
    logic [NIN-1:0]  r_grant;
    logic [NIN-1:0]  w_grant_nxt;
    logic [CW-1:0]   r_def [NIN];
    logic [CW-1:0]   w_def_nxt [NIN];

    logic [CW-1:0]   w_def_cur;
    logic [QW-1:0]   w_q_cur;
    logic [CW-1:0]   w_credit;
    logic [WBITS:0]  w_nbytes;
    logic [CW:0]     w_diff;
    logic [CW-1:0]   w_charge;
    logic            w_def_pos;
    logic            w_eop;

    assign w_def_cur = r_def[r_ptr];
    assign w_q_cur   = i_quantum[int'(r_ptr)*QW +: QW];
    assign w_ptr_inc = (r_ptr == PW'(NIN-1)) ? '0 : r_ptr + 1'b1;
    assign w_def_pos = !w_def_cur[CW-1] && (w_def_cur != '0);

    // Credit only lands on a non-positive deficit, so it cannot overflow.
    assign w_credit = w_def_cur + {{(CW-QW){1'b0}}, w_q_cur};

    assign w_nbytes = (i_bytes == '0) ? FULL_BEAT : {1'b0, i_bytes};
    assign w_diff   = {w_def_cur[CW-1], w_def_cur}
                    - {{(CW-WBITS){1'b0}}, w_nbytes};
    // Only negative overflow is possible: clamp instead of wrapping.
    assign w_charge = (w_diff[CW] != w_diff[CW-1]) ? DEF_MIN
                                                   : w_diff[CW-1:0];
    assign w_eop    = (i_beat && i_last) || i_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_fresh_nxt = r_fresh;
        w_grant_nxt = r_grant;
        for (int k = 0; k < NIN; k++) begin
            w_def_nxt[k] = r_def[k];
        end
        unique case (r_state)
            SCAN: begin
                if (!i_req[r_ptr]) begin
                    w_def_nxt[r_ptr] = '0;
                    w_ptr_nxt        = w_ptr_inc;
                    w_fresh_nxt      = 1'b1;
                end else if (r_fresh) begin
                    w_def_nxt[r_ptr] = w_credit;
                    w_fresh_nxt      = 1'b0;
                end else if (w_def_pos) begin
                    w_grant_nxt        = '0;
                    w_grant_nxt[r_ptr] = 1'b1;
                    w_state_nxt        = PKT;
                end else begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_fresh_nxt = 1'b1;
                end
            end
            PKT: begin
                if (i_beat) begin
                    w_def_nxt[r_ptr] = w_charge;
                end
                if (w_eop) begin
                    w_grant_nxt = '0;
                    w_fresh_nxt = 1'b0;
                    w_state_nxt = SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= SCAN;
            r_ptr   <= '0;
            r_fresh <= 1'b1;
            r_grant <= '0;
            for (int k = 0; k < NIN; k++) begin
                r_def[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_fresh <= w_fresh_nxt;
            r_grant <= w_grant_nxt;
            for (int k = 0; k < NIN; k++) begin
                r_def[k] <= w_def_nxt[k];
            end
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == PKT);
    assign o_ptr   = r_ptr;

endmodule

// File: tb/tb_axin_drr_sched.sv
// Directed bench for axin_drr_sched: a scoreboard of expected grant
// windows (port, rise cycle, fall cycle) checked by a decoupled monitor.
module tb_axin_drr_sched;

    logic        i_clk;
    logic        i_reset_n;
    logic [3:0]  i_req;
    logic [47:0] i_quantum;
    logic        i_beat;
    logic [2:0]  i_bytes;
    logic        i_last;
    logic        i_abort;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic [1:0]  o_ptr;

    axin_drr_sched dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_quantum (i_quantum),
        .i_beat    (i_beat),
        .i_bytes   (i_bytes),
        .i_last    (i_last),
        .i_abort   (i_abort),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_ptr     (o_ptr)
    );

    typedef struct {
        int port;
        int rise;
        int fall;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  cur;
    logic cur_valid = 1'b0;
    logic sb_on     = 1'b0;
    logic inv_bad   = 1'b0;
    int   nvec      = 0;
    int   nerr      = 0;
    int   cyc       = 0;
    int   base      = 0;

    // per-port source behaviour: beats, last-beat byte code, end kind
    // kind 0: i_last on final beat, 1: abort alone after beats,
    // kind 2: abort together with final beat
    int nb[4];
    int lb[4];
    int kd[4];
    int bytes_s[4];
    int pkts[4];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    // Source model: plays one packet per grant window
    initial begin
        logic active;
        int   gp;
        int   bi;
        logic done;
        logic fin;
        active = 1'b0;
        gp = 0;
        bi = 0;
        forever begin
            @(negedge i_clk);
            i_beat  = 1'b0;
            i_last  = 1'b0;
            i_abort = 1'b0;
            i_bytes = 3'd0;
            if (!i_reset_n) begin
                active = 1'b0;
            end else begin
                if (!active && o_grant != 4'd0) begin
                    for (int k = 0; k < 4; k++)
                        if (o_grant[k]) gp = k;
                    active = 1'b1;
                    bi = 0;
                    pkts[gp]++;
                end
                if (active) begin
                    done = 1'b0;
                    if (bi < nb[gp]) begin
                        fin = (bi == nb[gp] - 1);
                        i_beat  = 1'b1;
                        i_bytes = fin ? 3'(lb[gp]) : 3'd0;
                        bytes_s[gp] += (i_bytes == 3'd0) ? 8 : int'(i_bytes);
                        if (fin && kd[gp] == 0) begin
                            i_last = 1'b1;
                            done = 1'b1;
                        end
                        if (fin && kd[gp] == 2) begin
                            i_abort = 1'b1;
                            done = 1'b1;
                        end
                    end else begin
                        i_abort = 1'b1;
                        done = 1'b1;
                    end
                    bi++;
                    if (done) active = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation on each grant rise, checks its fall
    initial begin
        logic [3:0] prev;
        logic [3:0] want;
        prev = 4'd0;
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                if (!$onehot0(o_grant) || (o_busy != (o_grant != 4'd0)))
                    inv_bad = 1'b1;
                if (prev == 4'd0 && o_grant != 4'd0 && sb_on) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nerr++;
                        $display("FAIL grant_rise: got %b at cycle %0d, expected none",
                                 o_grant, cyc - base);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_valid = 1'b1;
                        want = 4'b0001 << cur.port;
                        if (o_grant != want || cyc - base != cur.rise) begin
                            nerr++;
                            $display("FAIL grant_rise: got %b at cycle %0d, expected %b at cycle %0d",
                                     o_grant, cyc - base, want, cur.rise);
                        end
                    end
                end else if (prev != 4'd0 && o_grant == 4'd0 && cur_valid) begin
                    cur_valid = 1'b0;
                    if (cur.fall >= 0) begin
                        nvec++;
                        if (cyc - base != cur.fall) begin
                            nerr++;
                            $display("FAIL grant_fall: port %0d dropped at cycle %0d, expected %0d",
                                     cur.port, cyc - base, cur.fall);
                        end
                    end
                end
            end
            prev = o_grant;
        end
    end

    task automatic check(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic setq(input int q0, input int q1, input int q2, input int q3);
        i_quantum = {12'(q3), 12'(q2), 12'(q1), 12'(q0)};
    endtask

    task automatic setpkt(input int n, input int l, input int k);
        for (int p = 0; p < 4; p++) begin
            nb[p] = n;
            lb[p] = l;
            kd[p] = k;
        end
    endtask

    task automatic rst_start();
        sb_on = 1'b0;
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        cur_valid = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin
            bytes_s[p] = 0;
            pkts[p] = 0;
        end
    endtask

    task automatic rst_release();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        base = cyc;
        sb_on = 1'b1;
    endtask

    task automatic wait_to(input int rel);
        while (cyc - base < rel) @(negedge i_clk);
    endtask

    task automatic drain(input string name, input int budget, input logic need_fall);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (need_fall && cur_valid)) && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        if (n >= budget) begin
            nvec++;
            nerr++;
            $display("FAIL %s_drain: %0d grants still pending, expected 0",
                     name, exp_q.size());
        end
        sb_on = 1'b0;
    endtask

    initial begin
        int n;
        int d;
        i_reset_n = 1'b0;
        i_req     = 4'd0;
        i_beat    = 1'b0;
        i_bytes   = 3'd0;
        i_last    = 1'b0;
        i_abort   = 1'b0;
        setq(0, 0, 0, 0);
        setpkt(8, 0, 0);
        for (int p = 0; p < 4; p++) begin
            bytes_s[p] = 0;
            pkts[p] = 0;
        end

        // reset state
        repeat (3) @(negedge i_clk);
        check("rst_grant", int'(o_grant), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ptr", int'(o_ptr), 0);

        // single port, Q0=64, 8 full beats; req dropped mid third packet
        setq(64, 64, 64, 64);
        setpkt(8, 0, 0);
        i_req = 4'b0001;
        exp_q.push_back('{0, 2, 10});
        exp_q.push_back('{0, 16, 24});
        exp_q.push_back('{0, 30, 38});
        rst_release();
        wait_to(33);
        i_req = 4'b0000;
        drain("single", 200, 1'b1);

        // two ports: 72-byte packets on port 0, 40-byte on port 1
        rst_start();
        setq(64, 64, 64, 64);
        setpkt(8, 0, 0);
        nb[0] = 9;
        nb[1] = 5;
        i_req = 4'b0011;
        exp_q.push_back('{0, 2, 11});
        exp_q.push_back('{1, 14, 19});
        exp_q.push_back('{1, 20, 25});
        exp_q.push_back('{0, 30, 39});
        exp_q.push_back('{1, 42, 47});
        exp_q.push_back('{1, 48, 53});
        exp_q.push_back('{0, 58, 67});
        exp_q.push_back('{1, 70, 75});
        rst_release();
        drain("two_port", 300, 1'b1);
        wait_to(400);
        n = 0;
        while (o_ptr != 2'd2 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("two_port_round_sync", (n < 200) ? 1 : 0, 1);
        d = bytes_s[0] - bytes_s[1];
        if (d < 0) d = -d;
        check("two_port_byte_balance", (d < 72) ? 1 : 0, 1);
        check("two_port_p1_more_pkts", (pkts[1] > pkts[0]) ? 1 : 0, 1);

        // quantum 0 on port 2, all ports requesting
        rst_start();
        setq(64, 64, 0, 64);
        setpkt(8, 0, 0);
        i_req = 4'b1111;
        exp_q.push_back('{0, 2, 10});
        exp_q.push_back('{1, 13, 21});
        exp_q.push_back('{3, 26, 34});
        exp_q.push_back('{0, 37, 45});
        rst_release();
        drain("q0", 200, 1'b1);
        wait_to(1000);
        check("q0_port2_pkts", pkts[2], 0);
        check("q0_port0_active", (pkts[0] >= 20) ? 1 : 0, 1);
        check("q0_port1_active", (pkts[1] >= 20) ? 1 : 0, 1);
        check("q0_port3_active", (pkts[3] >= 20) ? 1 : 0, 1);

        // abort alone after 3 full beats on port 1
        rst_start();
        setq(0, 64, 0, 0);
        setpkt(3, 0, 1);
        i_req = 4'b0010;
        exp_q.push_back('{1, 3, 7});
        exp_q.push_back('{1, 8, 12});
        exp_q.push_back('{1, 13, 17});
        exp_q.push_back('{1, 23, 27});
        rst_release();
        wait_to(7);
        check("abort_def", int'($signed(dut.r_def[1])), 40);
        drain("abort", 100, 1'b1);

        // abort together with a 4-byte beat, Q1=8
        rst_start();
        setq(0, 8, 0, 0);
        setpkt(1, 4, 2);
        i_req = 4'b0010;
        exp_q.push_back('{1, 3, 4});
        exp_q.push_back('{1, 5, 6});
        exp_q.push_back('{1, 12, 13});
        exp_q.push_back('{1, 14, 15});
        rst_release();
        wait_to(4);
        check("abort_beat_def", int'($signed(dut.r_def[1])), 4);
        drain("abort_beat", 100, 1'b1);

        // saturation: Q0=8, one 5000-beat packet, then 4097 credits
        rst_start();
        setq(8, 8, 8, 8);
        setpkt(5000, 0, 0);
        i_req = 4'b0001;
        exp_q.push_back('{0, 2, 5002});
        exp_q.push_back('{0, 25488, -1});
        rst_release();
        wait_to(5002);
        check("sat_def", int'($signed(dut.r_def[0])), -32768);
        drain("sat", 26000, 1'b0);
        repeat (20) @(negedge i_clk);

        // asynchronous reset mid-packet, away from a clock edge
        check("mid_pkt_busy", int'(o_busy), 1);
        @(posedge i_clk);
        #3 i_reset_n = 1'b0;
        #1;
        check("async_rst_grant", int'(o_grant), 0);
        check("async_rst_busy", int'(o_busy), 0);
        cur_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        base = cyc;
        check("post_rst_ptr", int'(o_ptr), 0);
        check("post_rst_def0", int'($signed(dut.r_def[0])), 0);
        @(negedge i_clk);
        check("post_rst_credit_def0", int'($signed(dut.r_def[0])), 8);

        check("onehot_busy_invariant", int'(inv_bad), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
